// File: rtl/cursor_grid_ctrl.sv
// Grid-stepped cursor overlay: tracks the cursor cell, steps it with wrap-around on
// move pulses, and renders a blinking hollow square with a select-flash colour.
module cursor_grid_ctrl #(
   parameter int          FOOTPRINT    = 32,
   parameter int          THICK        = 1,
   parameter int          PITCH        = 32,
   parameter int          GRID_COLS    = 9,
   parameter int          GRID_ROWS    = 9,
   parameter int          ORIGIN_X     = 176,
   parameter int          ORIGIN_Y     = 96,
   parameter int          INIT_COL     = 0,
   parameter int          INIT_ROW     = 0,
   parameter int          BLINK_HALF   = 12500000,
   parameter int          FLASH_CYCLES = 6250000,
   parameter logic [11:0] COLOR        = 12'h000,
   parameter logic [11:0] SEL_COLOR    = 12'hF00,
   parameter int          CW           = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1,
   parameter int          RW           = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [9:0]    pixel_x,
   input  logic [9:0]    pixel_y,
   input  logic          move_up,
   input  logic          move_down,
   input  logic          move_left,
   input  logic          move_right,
   input  logic          select,
   input  logic          blink_en,
   output logic [CW-1:0] cur_col,
   output logic [RW-1:0] cur_row,
   output logic          moved,
   output logic          on,
   output logic [11:0]   color
);

   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam int FW = (FLASH_CYCLES > 0) ? $clog2(FLASH_CYCLES + 1) : 1;

   localparam logic signed [11:0] ZERO_S  = 12'sd0;
   localparam logic signed [11:0] FP_S    = 12'(FOOTPRINT);
   localparam logic signed [11:0] THICK_S = 12'(THICK);
   localparam logic signed [11:0] INNER_S = 12'(FOOTPRINT - THICK);

   typedef enum logic {
      PH_VISIBLE = 1'b0,
      PH_HIDDEN  = 1'b1
   } phase_t;

   logic [CW-1:0] cur_col_q, cur_col_d;
   logic [RW-1:0] cur_row_q, cur_row_d;
   logic          moved_q, moved_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   phase_t        phase_q, phase_d;
   logic [FW-1:0] flash_cnt_q, flash_cnt_d;
   logic          on_q, on_d;
   logic [11:0]   color_q, color_d;

   logic                 pos_change;
   logic                 flash_active;
   logic [10:0]          left, top;
   logic signed [11:0]   dx, dy;
   logic                 inbox, border;

   always_comb begin
      cur_col_d = cur_col_q;
      if (move_right && !move_left) begin
         cur_col_d = (cur_col_q == CW'(GRID_COLS - 1)) ? '0 : cur_col_q + CW'(1);
      end else if (move_left && !move_right) begin
         cur_col_d = (cur_col_q == '0) ? CW'(GRID_COLS - 1) : cur_col_q - CW'(1);
      end

      cur_row_d = cur_row_q;
      if (move_down && !move_up) begin
         cur_row_d = (cur_row_q == RW'(GRID_ROWS - 1)) ? '0 : cur_row_q + RW'(1);
      end else if (move_up && !move_down) begin
         cur_row_d = (cur_row_q == '0) ? RW'(GRID_ROWS - 1) : cur_row_q - RW'(1);
      end

      pos_change = (cur_col_d != cur_col_q) || (cur_row_d != cur_row_q);
      moved_d    = pos_change;
   end

   // A move restarts the blink so the cursor is shown right where it landed.
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if (pos_change || !blink_en) begin
         blink_cnt_d = '0;
         phase_d     = PH_VISIBLE;
      end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
         blink_cnt_d = '0;
         phase_d     = (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
      end else begin
         blink_cnt_d = blink_cnt_q + BW'(1);
      end
   end

   always_comb begin
      flash_active = (flash_cnt_q != '0);
      flash_cnt_d  = flash_cnt_q;
      if (select) begin
         flash_cnt_d = FW'(FLASH_CYCLES);
      end else if (flash_active) begin
         flash_cnt_d = flash_cnt_q - FW'(1);
      end
   end

   // Signed offsets so pixels left of or above the box fall out as negative.
   always_comb begin
      left   = 11'(ORIGIN_X) + 11'(cur_col_q) * 11'(PITCH);
      top    = 11'(ORIGIN_Y) + 11'(cur_row_q) * 11'(PITCH);
      dx     = $signed({2'b00, pixel_x}) - $signed({1'b0, left});
      dy     = $signed({2'b00, pixel_y}) - $signed({1'b0, top});
      inbox  = (dx >= ZERO_S) && (dx < FP_S) && (dy >= ZERO_S) && (dy < FP_S);
      border = inbox && ((dx < THICK_S) || (dx >= INNER_S) ||
                         (dy < THICK_S) || (dy >= INNER_S));
      on_d    = border && ((phase_q == PH_VISIBLE) || flash_active);
      color_d = flash_active ? SEL_COLOR : COLOR;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_col_q   <= CW'(INIT_COL);
         cur_row_q   <= RW'(INIT_ROW);
         moved_q     <= 1'b0;
         blink_cnt_q <= '0;
         phase_q     <= PH_VISIBLE;
         flash_cnt_q <= '0;
         on_q        <= 1'b0;
         color_q     <= COLOR;
      end else begin
         cur_col_q   <= cur_col_d;
         cur_row_q   <= cur_row_d;
         moved_q     <= moved_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         flash_cnt_q <= flash_cnt_d;
         on_q        <= on_d;
         color_q     <= color_d;
      end
   end

   assign cur_col = cur_col_q;
   assign cur_row = cur_row_q;
   assign moved   = moved_q;
   assign on      = on_q;
   assign color   = color_q;

endmodule

// File: tb/tb_cursor_grid_ctrl.sv
// Directed bench for cursor_grid_ctrl: one instance with THICK=1 and one with THICK=2
// share all stimulus; expected values are hand-derived per step.
module tb_cursor_grid_ctrl;

   logic        clk;
   logic        reset;
   logic [9:0]  pixel_x, pixel_y;
   logic        move_up, move_down, move_left, move_right, select, blink_en;
   logic [3:0]  cur_col, cur_row, cur_col2, cur_row2;
   logic        moved, moved2, on, on2;
   logic [11:0] color, color2;

   int compared;
   int mismatched;
   int moved_count;
   logic [11:0] blink_pattern;

   cursor_grid_ctrl #(.BLINK_HALF(4), .FLASH_CYCLES(3)) dut (
      .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .move_up(move_up), .move_down(move_down), .move_left(move_left),
      .move_right(move_right), .select(select), .blink_en(blink_en),
      .cur_col(cur_col), .cur_row(cur_row), .moved(moved), .on(on), .color(color)
   );

   cursor_grid_ctrl #(.BLINK_HALF(4), .FLASH_CYCLES(3), .THICK(2)) dut_thick (
      .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .move_up(move_up), .move_down(move_down), .move_left(move_left),
      .move_right(move_right), .select(select), .blink_en(blink_en),
      .cur_col(cur_col2), .cur_row(cur_row2), .moved(moved2), .on(on2), .color(color2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one cycle of inputs, then samples just after the rising edge.
   task automatic applyStimulus(input int px, input int py, input logic up, input logic down,
                                input logic lft, input logic rgt, input logic sel);
      pixel_x    = 10'(px);
      pixel_y    = 10'(py);
      move_up    = up;
      move_down  = down;
      move_left  = lft;
      move_right = rgt;
      select     = sel;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      compared    = 0;
      mismatched  = 0;
      moved_count = 0;
      reset       = 1'b1;
      blink_en    = 1'b0;

      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("reset_col", 32'(cur_col), 32'd0);
      checkOutput("reset_row", 32'(cur_row), 32'd0);
      checkOutput("reset_moved", 32'(moved), 32'd0);
      checkOutput("reset_on", 32'(on), 32'd0);
      checkOutput("reset_color", 32'(color), 32'h000);
      reset = 1'b0;

      applyStimulus(176, 96, 0, 0, 0, 0, 0);
      checkOutput("corner_on", 32'(on), 32'd1);
      checkOutput("corner_color", 32'(color), 32'h000);
      checkOutput("thick_corner_on", 32'(on2), 32'd1);
      applyStimulus(177, 97, 0, 0, 0, 0, 0);
      checkOutput("inner_on", 32'(on), 32'd0);
      checkOutput("thick_177_97_on", 32'(on2), 32'd1);
      applyStimulus(178, 98, 0, 0, 0, 0, 0);
      checkOutput("thick_178_98_on", 32'(on2), 32'd0);
      applyStimulus(207, 127, 0, 0, 0, 0, 0);
      checkOutput("far_corner_on", 32'(on), 32'd1);
      applyStimulus(208, 96, 0, 0, 0, 0, 0);
      checkOutput("right_outside_on", 32'(on), 32'd0);
      applyStimulus(175, 96, 0, 0, 0, 0, 0);
      checkOutput("left_outside_on", 32'(on), 32'd0);

      for (int i = 1; i <= 8; i++) begin
         applyStimulus(176, 96, 0, 0, 0, 1, 0);
         if (moved) moved_count++;
         checkOutput($sformatf("right_step%0d_col", i), 32'(cur_col), 32'(i));
         applyStimulus(176, 96, 0, 0, 0, 0, 0);
         if (moved) moved_count++;
      end
      checkOutput("moved_pulse_count", 32'(moved_count), 32'd8);
      applyStimulus(432, 96, 0, 0, 0, 0, 0);
      checkOutput("col8_corner_on", 32'(on), 32'd1);
      applyStimulus(432, 96, 0, 0, 0, 1, 0);
      checkOutput("wrap_right_col", 32'(cur_col), 32'd0);
      applyStimulus(176, 96, 0, 0, 1, 0, 0);
      checkOutput("wrap_left_col", 32'(cur_col), 32'd8);
      applyStimulus(176, 96, 0, 0, 0, 1, 0);
      checkOutput("back_to_col0", 32'(cur_col), 32'd0);
      applyStimulus(176, 96, 0, 0, 0, 0, 0);

      applyStimulus(176, 96, 1, 1, 0, 1, 0);
      checkOutput("diag_row", 32'(cur_row), 32'd0);
      checkOutput("diag_col", 32'(cur_col), 32'd1);
      checkOutput("diag_moved", 32'(moved), 32'd1);
      applyStimulus(176, 96, 0, 0, 0, 0, 0);
      checkOutput("diag_moved_single", 32'(moved), 32'd0);
      applyStimulus(176, 96, 0, 0, 1, 0, 0);
      applyStimulus(176, 96, 0, 0, 0, 0, 0);
      checkOutput("idle_col0", 32'(cur_col), 32'd0);

      blink_en      = 1'b1;
      blink_pattern = 12'b1111_0000_1111;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(176, 96, 0, 0, 0, 0, 0);
         checkOutput($sformatf("blink_%0d_on", i), 32'(on), 32'(blink_pattern[11 - i]));
      end
      applyStimulus(176, 96, 0, 0, 0, 0, 0);
      checkOutput("hidden_before_move_on", 32'(on), 32'd0);
      applyStimulus(176, 128, 0, 1, 0, 0, 0);
      checkOutput("move_down_row", 32'(cur_row), 32'd1);
      checkOutput("move_down_moved", 32'(moved), 32'd1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(176, 128, 0, 0, 0, 0, 0);
         checkOutput($sformatf("post_move_%0d_on", i), 32'(on), 32'd1);
      end
      applyStimulus(176, 128, 0, 0, 0, 0, 0);
      checkOutput("post_move_hidden_on", 32'(on), 32'd0);

      applyStimulus(176, 128, 0, 0, 0, 0, 1);
      checkOutput("select_edge_on", 32'(on), 32'd0);
      checkOutput("select_edge_color", 32'(color), 32'h000);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(176, 128, 0, 0, 0, 0, 0);
         checkOutput($sformatf("flash_%0d_on", i), 32'(on), 32'd1);
         checkOutput($sformatf("flash_%0d_color", i), 32'(color), 32'hF00);
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(176, 128, 0, 0, 0, 0, 0);
         checkOutput($sformatf("resume_%0d_on", i), 32'(on), 32'd1);
         checkOutput($sformatf("resume_%0d_color", i), 32'(color), 32'h000);
      end
      applyStimulus(176, 128, 0, 0, 0, 0, 0);
      checkOutput("resume_hidden_on", 32'(on), 32'd0);

      applyStimulus(336, 192, 0, 1, 0, 1, 0);
      applyStimulus(336, 192, 0, 1, 0, 1, 0);
      applyStimulus(336, 192, 0, 0, 0, 1, 0);
      applyStimulus(336, 192, 0, 0, 0, 1, 0);
      applyStimulus(336, 192, 0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(336, 192, 0, 0, 0, 0, 0);
         checkOutput($sformatf("cell53_%0d_on", i), 32'(on), 32'd1);
      end
      applyStimulus(336, 192, 0, 0, 0, 0, 1);
      checkOutput("cell53_col", 32'(cur_col), 32'd5);
      checkOutput("cell53_row", 32'(cur_row), 32'd3);
      checkOutput("cell53_hidden_on", 32'(on), 32'd0);

      reset = 1'b1;
      applyStimulus(336, 192, 0, 0, 0, 0, 0);
      checkOutput("midreset_col", 32'(cur_col), 32'd0);
      checkOutput("midreset_row", 32'(cur_row), 32'd0);
      checkOutput("midreset_moved", 32'(moved), 32'd0);
      checkOutput("midreset_color", 32'(color), 32'h000);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(176, 96, 0, 0, 0, 0, 0);
         checkOutput($sformatf("release_%0d_on", i), 32'(on), 32'd1);
         checkOutput($sformatf("release_%0d_color", i), 32'(color), 32'h000);
      end
      applyStimulus(176, 96, 0, 0, 0, 0, 0);
      checkOutput("release_hidden_on", 32'(on), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/cursor_grid_ctrl.md
Name: cursor_grid_ctrl

Overview:
Grid-stepped cursor overlay for the VGA pixel pipeline. It holds the cursor cell position, which the move pulses step with wrap-around. It renders a hollow square of configurable footprint and border thickness at that cell, with optional blinking and a select-flash colour. It sits beside the tile and number renderers, and the pixel mux takes its registered on and colour outputs.

Parameters:
FOOTPRINT, 32, cursor square side in pixels
THICK, 1, border thickness in pixels (1 to FOOTPRINT/2)
PITCH, 32, pixel distance between adjacent cells (must be at least FOOTPRINT)
GRID_COLS, 9, number of cell columns
GRID_ROWS, 9, number of cell rows
ORIGIN_X, 176, pixel x of the top-left corner of cell (0,0)
ORIGIN_Y, 96, pixel y of the top-left corner of cell (0,0)
INIT_COL, 0, column loaded at reset
INIT_ROW, 0, row loaded at reset
BLINK_HALF, 12500000, clock cycles per blink half-period
FLASH_CYCLES, 6250000, clock cycles the select colour is held
COLOR, 12'h000, normal cursor colour
SEL_COLOR, 12'hF00, colour shown during a select flash

Ports:
clk  in  1  pixel-domain clock
reset  in  1  synchronous, active-high reset
pixel_x  in  10  current scan x
pixel_y  in  10  current scan y
move_up  in  1  single-cycle pulse: row-1
move_down  in  1  single-cycle pulse: row+1
move_left  in  1  single-cycle pulse: col-1
move_right  in  1  single-cycle pulse: col+1
select  in  1  single-cycle pulse: start select flash
blink_en  in  1  1 enables blinking, 0 keeps the cursor always visible
cur_col  out  CW=clog2(GRID_COLS)  current column
cur_row  out  RW=clog2(GRID_ROWS)  current row
moved  out  1  one-cycle pulse when the position changed
on  out  1  registered: pixel is on the cursor border and visible
color  out  12  registered cursor colour

Behaviour:
- One clock (clk). Reset is synchronous and active-high and takes priority over every other input.
- Reset values:
  - cur_col=INIT_COL, cur_row=INIT_ROW.
  - moved=0, on=0, color=COLOR.
  - Blink counter=0 and phase=visible.
  - Flash counter=0.
- Column update, per cycle:
  - move_right and move_left together: no change.
  - move_right alone: col+1; GRID_COLS-1 wraps to 0.
  - move_left alone: col-1; 0 wraps to GRID_COLS-1.
- Row update, per cycle: same rules using move_down/move_up and GRID_ROWS.
- Horizontal and vertical updates are independent, so a diagonal move in one cycle is legal.
- moved: registered. It is 1 in the cycle after any column or row change, otherwise 0.
- Any column or row change also clears the blink counter and forces phase=visible, so the cursor is shown immediately after a move.
- Blink:
  - The counter counts 0 to BLINK_HALF-1. At terminal count it returns to 0 and toggles the phase.
  - With blink_en=0 the counter and phase are held at 0/visible.
- Flash:
  - A select pulse loads the flash counter with FLASH_CYCLES. The counter decrements to 0.
  - select while the counter is nonzero reloads it.
  - While the counter is nonzero the cursor is forced visible, even if blink is in the hidden phase.
- Geometry, computed on the current pixel:
  - left = ORIGIN_X + cur_col*PITCH, top = ORIGIN_Y + cur_row*PITCH. Use 11-bit arithmetic so the sum cannot overflow.
  - dx = pixel_x - left, dy = pixel_y - top.
  - inbox: 0 <= dx < FOOTPRINT and 0 <= dy < FOOTPRINT, using signed comparison so pixels left of or above the box are rejected.
  - border: inbox and (dx < THICK, or dx >= FOOTPRINT-THICK, or dy < THICK, or dy >= FOOTPRINT-THICK).
- Output register:
  - on <= border AND (phase visible OR flash counter nonzero).
  - color <= SEL_COLOR if the flash counter is nonzero, else COLOR.
  - Latency is exactly 1 cycle from pixel_x/pixel_y to on/color.
  - Rendering uses the position as it stands before the same-cycle move update (registered cur_col/cur_row).

Test Plan:
- Defaults with BLINK_HALF=4, FLASH_CYCLES=3, blink_en=0:
  - Hold reset 2 cycles, then pixel (176,96) -> on=1 one cycle later, color=12'h000.
  - (177,97) -> on=0.
  - (207,127) -> on=1.
  - (208,96) -> on=0.
  - (175,96) -> on=0.
- Column wrap:
  - 8 move_right pulses -> cur_col=8 and moved pulses 8 times. Pixel (432,96) -> on=1.
  - A 9th pulse -> cur_col=0.
  - move_left at col 0 -> cur_col=8.
- Simultaneous moves: move_up+move_down+move_right in one cycle from (0,0) -> cur_row=0, cur_col=1, single moved pulse.
- Blink and move reset:
  - blink_en=1, pixel fixed on the border -> on pattern 1111 0000 1111.
  - move_down during the hidden phase -> on=1 on the next cycle and stays 1 for 4 cycles.
- Select flash and border thickness:
  - select during the hidden phase -> on=1 and color=12'hF00 for 3 cycles, then the blink pattern resumes.
  - With THICK=2: pixel (177,97) -> on=1, pixel (178,98) -> on=0.
- Reset mid-operation: at col=5, row=3, blink hidden, flash active, assert reset 1 cycle -> cur_col=0, cur_row=0, moved=0, color=12'h000, visible phase on release.
